// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin pattern loader with per-pattern match dwell and report
module seq_det_scheduler #(
    parameter int K     = 3,
    parameter int N     = 4,
    parameter int DWELL = 8,
    parameter int CW    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [N-1:0]           req_valid,
    input  logic [N*K-1:0]         req_pattern,
    output logic [N-1:0]           req_ready,
    output logic [K-1:0]           det_pattern,
    output logic                   det_valid,
    input  logic                   det_ready,
    input  logic                   det_match,
    output logic                   rpt_valid,
    output logic [$clog2(N)-1:0]   rpt_id,
    output logic [CW-1:0]          rpt_count
);
    localparam int IW  = $clog2(N);
    localparam int DCW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_REPORT} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic            grant_fire;
    logic [IW:0]     cand;
    logic [K-1:0]    pat [N];
    logic [DCW-1:0]  dwell_cnt;
    logic [CW-1:0]   match_cnt;
    logic [CW-1:0]   match_next;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pat[i] = req_pattern[i*K +: K];
        end
    end

    // First requesting index after last_grant, wrapping modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last_grant} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_found && req_valid[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    assign grant_fire = rstn && (state == S_IDLE) && en && grant_found;
    assign req_ready  = grant_fire ? (N'(1) << grant_idx) : '0;

    always_comb begin
        match_next = match_cnt;
        if (det_match && (match_cnt != {CW{1'b1}})) begin
            match_next = match_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            last_grant  <= IW'(N - 1);
            grant_id    <= '0;
            det_valid   <= 1'b0;
            det_pattern <= '0;
            rpt_valid   <= 1'b0;
            rpt_id      <= '0;
            rpt_count   <= '0;
            match_cnt   <= '0;
            dwell_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_fire) begin
                        last_grant  <= grant_idx;
                        grant_id    <= grant_idx;
                        det_pattern <= pat[grant_idx];
                        det_valid   <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (det_ready) begin
                        det_valid <= 1'b0;
                        match_cnt <= '0;
                        dwell_cnt <= '0;
                        state     <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    match_cnt <= match_next;
                    dwell_cnt <= dwell_cnt + DCW'(1);
                    if (dwell_cnt == DCW'(DWELL - 1)) begin
                        rpt_valid <= 1'b1;
                        rpt_id    <= grant_id;
                        rpt_count <= match_next;
                        state     <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    rpt_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb/tb_seq_det_scheduler.sv - scoreboard bench for seq_det_scheduler (CW=4 and CW=2 instances)
module tb_seq_det_scheduler;
    localparam int K = 3;
    localparam int N = 4;
    localparam int DWELL = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N*K-1:0] req_pattern;
    logic           det_ready;
    logic           det_match;

    logic [N-1:0]   req_ready,   req_ready2;
    logic [K-1:0]   det_pattern, det_pattern2;
    logic           det_valid,   det_valid2;
    logic           rpt_valid,   rpt_valid2;
    logic [1:0]     rpt_id,      rpt_id2;
    logic [3:0]     rpt_count;
    logic [1:0]     rpt_count2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_t = 0;

    typedef struct {
        int cyc;
        int id;
        int cnt;
        int cnt_sat;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    bit   have_rpt = 1'b0;
    int   held_id;
    int   held_cnt;

    seq_det_scheduler #(.K(K), .N(N), .DWELL(DWELL), .CW(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .req_valid(req_valid), .req_pattern(req_pattern),
        .req_ready(req_ready), .det_pattern(det_pattern), .det_valid(det_valid),
        .det_ready(det_ready), .det_match(det_match), .rpt_valid(rpt_valid),
        .rpt_id(rpt_id), .rpt_count(rpt_count)
    );

    seq_det_scheduler #(.K(K), .N(N), .DWELL(DWELL), .CW(2)) dut_sat (
        .clk(clk), .rstn(rstn), .en(en), .req_valid(req_valid), .req_pattern(req_pattern),
        .req_ready(req_ready2), .det_pattern(det_pattern2), .det_valid(det_valid2),
        .det_ready(det_ready), .det_match(det_match), .rpt_valid(rpt_valid2),
        .rpt_id(rpt_id2), .rpt_count(rpt_count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected report per rpt_valid strobe.
    always @(negedge clk) begin
        if (rpt_valid || rpt_valid2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: got rpt_valid=%0d/%0d expected none (cycle %0d)",
                         rpt_valid, rpt_valid2, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rpt_valid", int'(rpt_valid), 1);
                check("rpt_valid_sat", int'(rpt_valid2), 1);
                check("rpt_cycle", cyc, e.cyc);
                check("rpt_id", int'(rpt_id), e.id);
                check("rpt_count", int'(rpt_count), e.cnt);
                check("rpt_count_sat", int'(rpt_count2), e.cnt_sat);
                have_rpt = 1'b1;
                held_id  = e.id;
                held_cnt = e.cnt;
            end
        end else if (!rstn) begin
            have_rpt = 1'b0;
        end else if (have_rpt) begin
            check("rpt_id_hold", int'(rpt_id), held_id);
            check("rpt_count_hold", int'(rpt_count), held_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input int exp_id, input logic [N-1:0] valid, input logic [K-1:0] pat,
                          input int stall, input logic [7:0] mmask, input bit chk_gap);
        logic [N*K-1:0] rp;
        int t;
        int c;
        rp = {$urandom, $urandom};
        rp[exp_id*K +: K] = pat;
        req_valid   = valid;
        req_pattern = rp;
        en          = 1'b1;
        det_ready   = (stall == 0);
        det_match   = 1'b1;
        @(negedge clk);
        check("grant_ready", int'(req_ready), 1 << exp_id);
        t = cyc;
        if (chk_gap) check("grant_gap", t - last_t, 3 + DWELL);
        last_t = t;
        c = $countones(mmask);
        exp_q.push_back('{t + 2 + DWELL + stall, exp_id, c, (c > 3) ? 3 : c});
        step();
        for (int s = 0; s <= stall; s++) begin
            det_ready = (s == stall);
            det_match = 1'b1;
            req_pattern = {$urandom, $urandom};
            @(negedge clk);
            check("load_valid", int'(det_valid), 1);
            check("load_pattern", int'(det_pattern), int'(pat));
            check("load_ready_zero", int'(req_ready), 0);
            step();
        end
        for (int d = 0; d < DWELL; d++) begin
            det_match = mmask[d];
            det_ready = 1'($urandom);
            en        = 1'($urandom);
            @(negedge clk);
            check("dwell_det_valid", int'(det_valid), 0);
            check("dwell_ready_zero", int'(req_ready), 0);
            step();
        end
        det_match = 1'b1;
        en        = 1'b1;
        @(negedge clk);
        check("report_ready_zero", int'(req_ready), 0);
        step();
    endtask

    initial begin
        rstn        = 1'b0;
        en          = 1'b1;
        req_valid   = '1;
        req_pattern = '0;
        det_ready   = 1'b1;
        det_match   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", int'(req_ready), 0);
            check("rst_det_valid", int'(det_valid), 0);
            check("rst_rpt_valid", int'(rpt_valid), 0);
            check("rst_rpt_id", int'(rpt_id), 0);
            check("rst_rpt_count", int'(rpt_count), 0);
        end
        step();
        rstn = 1'b1;

        // Fairness with all requesters held: 0,1,2,3,0, 11 cycles apart
        do_txn(0, 4'b1111, 3'b001, 0, 8'b0000_0001, 1'b0);
        do_txn(1, 4'b1111, 3'b010, 0, 8'b0000_0011, 1'b1);
        do_txn(2, 4'b1111, 3'b011, 0, 8'b0000_0000, 1'b1);
        do_txn(3, 4'b1111, 3'b100, 0, 8'b1111_0000, 1'b1);
        do_txn(0, 4'b1111, 3'b110, 0, 8'b0101_0101, 1'b1);

        // Single request, three matches in the dwell window
        do_txn(2, 4'b0100, 3'b101, 0, 8'b1001_0010, 1'b0);

        // Backpressure: five stalled LOAD cycles
        do_txn(0, 4'b0001, 3'b111, 5, 8'b1000_0001, 1'b0);

        // Saturation: 8 matches -> 8 at CW=4, 3 at CW=2
        do_txn(3, 4'b1000, 3'b010, 0, 8'hFF, 1'b0);

        // Gating: en=0 blocks grants
        en        = 1'b0;
        req_valid = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            check("gated_ready", int'(req_ready), 0);
            step();
            @(negedge clk);
            check("gated_det_valid", int'(det_valid), 0);
        end

        // Abort: reset in the 4th dwell cycle, no report, priority back to 0
        step();
        en        = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("abort_grant", int'(req_ready), 4'b0100);
        step();
        repeat (4) step();
        rstn      = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("abort_rst_ready", int'(req_ready), 0);
        step();
        rstn = 1'b1;
        do_txn(0, 4'b1111, 3'b011, 0, 8'b0010_0100, 1'b0);

        req_valid = '0;
        repeat (4) step();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
